idex_hazard_ctrl: RTL and testbench
===================================

# idex_hazard_ctrl

Pipeline sequencing controller for the ID/EX pipeline register of the integer/float MIPS core. It detects load-use RAW hazards across the integer and FP register files, including double-word FP register pairs. It sequences multi-cycle FP divide occupancy of EX and applies branch flushes. It drives the write-enables and bubble controls for PC, IF/ID and ID/EX, plus a bubble into EX/MEM, and keeps a saturating stall-cycle counter.

## Interface
- FDIV_LAT, 8, total EX-stage cycles of an FP divide; legal range 2..65535
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_rs_vld, id_rt_vld  in  1 each  corresponding source is actually read
- id_src_float  in  1  ID sources are in the FP register file
- ex_dst, mem_dst  in  5 each  destination register of the EX / MEM instruction
- ex_rwrite, mem_rwrite  in  1 each  stage writes a register
- ex_float, mem_float  in  1 each  destination is in the FP file
- ex_dw, mem_dw  in  1 each  destination is a double-word even/odd FP pair
- ex_is_load, mem_is_load  in  1 each  write-back source is memory
- fdiv_start  in  1  FP divide is in its first EX cycle; single-cycle pulse
- branch_taken  in  1  branch resolved taken in EX
- pc_we, ifid_we, idex_we  out  1 each  register write-enables
- ifid_flush  out  1  IF/ID loads NOP
- idex_bubble  out  1  ID/EX loads all-zero control fields
- exmem_bubble  out  1  EX/MEM loads all-zero control fields
- fpu_busy  out  1  FP divide occupying EX
- stall_cycles  out  16  count of cycles with pc_we=0, saturating

## Operation
- States:
  - RUN.
  - FBUSY: holds a counter cnt of width clog2(FDIV_LAT).
- Register match m(src, dst, dw, flt) = 1 when all of the following hold:
  - the source is valid;
  - id_src_float == flt;
  - the registers match: if dw, src[4:1]==dst[4:1]; otherwise src==dst.
- Integer register 0 never matches when flt=0.
- Hazard evaluation is performed in RUN, and in the final FBUSY cycle where cnt==0.
- Evaluation priority is top to bottom:
  1. fdiv_start: pc_we=ifid_we=idex_we=0, exmem_bubble=1. Load cnt=FDIV_LAT-2 and go to FBUSY.
  2. branch_taken: ifid_flush=1, idex_bubble=1, pc_we=ifid_we=idex_we=1.
  3. load-use, i.e. ex_is_load & ex_rwrite & m(rs or rt vs ex_*): pc_we=ifid_we=0, idex_we=1, idex_bubble=1.
  4. Otherwise all enables are 1 and all bubbles/flushes are 0.
- FBUSY with cnt!=0: pc_we=ifid_we=idex_we=0, exmem_bubble=1, cnt decrements.
- FBUSY with cnt==0: evaluate as RUN, then go to RUN. A new fdiv_start in this cycle re-enters FBUSY.
- fdiv_start received while in FBUSY with cnt!=0 is ignored.
- fpu_busy = (state==FBUSY) | fdiv_start.
- stall_cycles increments on every cycle with pc_we=0 and holds at 16'hFFFF.
- fdiv_start and branch_taken asserted together is a protocol violation. fdiv_start wins and branch_taken is dropped.

## Timing
- All outputs except stall_cycles are combinational from state, cnt and the current inputs.
- State, cnt and stall_cycles update on the rising edge of clk.
- Reset (rst_n=0) forces state=RUN, cnt=0 and stall_cycles=0 immediately.
- Outputs during reset with inputs idle:
  - pc_we=ifid_we=idex_we=1;
  - ifid_flush=idex_bubble=exmem_bubble=fpu_busy=0.
- Deasserting reset mid-divide abandons the divide. The pipeline resumes in RUN on the next edge.
- Load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and is covered by forwarding, or by the non-forwarding check below.
- FP divide: EX occupancy is exactly FDIV_LAT cycles.
  - The start cycle plus FDIV_LAT-2 FBUSY cycles stall the pipeline, giving FDIV_LAT-1 stall cycles.
  - The cnt==0 cycle releases it.
- Branch flush has zero stall cycles and affects one cycle only.

## Configuration
- IDEX_FWD_EN defined: the EX/MEM-to-EX and MEM/WB-to-EX forwarding paths exist. Only the load-use rule (3) stalls.
- IDEX_FWD_EN undefined: there is no forwarding. Rule 3 is replaced by a RAW check against both stages, ex_rwrite&m(...,ex_*) | mem_rwrite&m(...,mem_*), regardless of the is_load flags.
  - Same stall response: pc_we=ifid_we=0, idex_bubble=1.
  - A dependent instruction stalls up to 2 cycles.
  - mem_is_load is unused.

## Test plan
- Reset: pulse rst_n low mid-FBUSY with cnt=3 -> immediately fpu_busy=0, stall_cycles=0, pc_we=1; RUN after release.
- Load-use: EX `lw $5`, ID `add` rs=5 -> one cycle with pc_we=0 and idex_bubble=1, then normal flow; stall_cycles=1. Same case with rs=0 and dst=0 -> no stall.
- Double-word pair: EX float load with ex_dw=1, dst=6; ID float source rt=7 -> stall. Same with id_src_float=0 -> no stall.
- FP divide, FDIV_LAT=8: fdiv_start at cycle 0 -> pc_we=0 for cycles 0..6, released at cycle 7; fpu_busy high for cycles 0..7; stall_cycles=7.
- Branch: branch_taken together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_we=1 (branch wins). Asserted with fdiv_start -> FBUSY entered, no flush.
- Saturation/config: preload 65534 stall cycles, then 3 more stalls -> stall_cycles=16'hFFFF. With IDEX_FWD_EN undefined: EX `add $3`, ID reads $3 -> 2 stall cycles.

Source files
------------

// File: rtl/idex_hazard_if.sv
// ID/EX hazard controller bundle: pipeline-state inputs and
// register-control outputs shared by the controller and its driver.
interface idex_hazard_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_vld;
  logic        id_rt_vld;
  logic        id_src_float;
  logic [4:0]  ex_dst;
  logic [4:0]  mem_dst;
  logic        ex_rwrite;
  logic        mem_rwrite;
  logic        ex_float;
  logic        mem_float;
  logic        ex_dw;
  logic        mem_dw;
  logic        ex_is_load;
  logic        mem_is_load;
  logic        fdiv_start;
  logic        branch_taken;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_bubble;
  logic        fpu_busy;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_rs_vld, id_rt_vld, id_src_float,
    output ex_dst, mem_dst, ex_rwrite, mem_rwrite,
    output ex_float, mem_float, ex_dw, mem_dw,
    output ex_is_load, mem_is_load, fdiv_start, branch_taken,
    input  pc_we, ifid_we, idex_we, ifid_flush,
    input  idex_bubble, exmem_bubble, fpu_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_rs_vld, id_rt_vld, id_src_float,
    input  ex_dst, mem_dst, ex_rwrite, mem_rwrite,
    input  ex_float, mem_float, ex_dw, mem_dw,
    input  ex_is_load, mem_is_load, fdiv_start, branch_taken,
    output pc_we, ifid_we, idex_we, ifid_flush,
    output idex_bubble, exmem_bubble, fpu_busy, stall_cycles
  );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// ID/EX sequencing: RAW/load-use stalls, FP divide occupancy, branch flush.
// IDEX_FWD_EN defined: forwarding present, only load-use stalls.
module idex_hazard_ctrl #(
  parameter int unsigned FDIV_LAT = 8
) (
  input logic           clk,
  input logic           rst_n,
  idex_hazard_if.slave  bus
);

  localparam int CW = $clog2(FDIV_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(FDIV_LAT - 2);

  typedef enum logic {RUN, FBUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stall_q, stall_d;

  logic pc_we, ifid_we, idex_we;
  logic ifid_flush, idex_bubble, exmem_bubble;
  logic eval, hit_ex, hit_mem, raw;

  function automatic logic m(
    input logic [4:0] src,
    input logic       vld,
    input logic       sflt,
    input logic [4:0] dst,
    input logic       dw,
    input logic       flt
  );
    logic eq;
    eq = dw ? (src[4:1] == dst[4:1]) : (src == dst);
    return vld & (sflt == flt) & eq & ~(~flt & (src == 5'd0));
  endfunction

  assign hit_ex =
    m(bus.id_rs, bus.id_rs_vld, bus.id_src_float,
      bus.ex_dst, bus.ex_dw, bus.ex_float) |
    m(bus.id_rt, bus.id_rt_vld, bus.id_src_float,
      bus.ex_dst, bus.ex_dw, bus.ex_float);

  assign hit_mem =
    m(bus.id_rs, bus.id_rs_vld, bus.id_src_float,
      bus.mem_dst, bus.mem_dw, bus.mem_float) |
    m(bus.id_rt, bus.id_rt_vld, bus.id_src_float,
      bus.mem_dst, bus.mem_dw, bus.mem_float);

`ifdef IDEX_FWD_EN
  logic unused_mem;
  assign raw = bus.ex_is_load & bus.ex_rwrite & hit_ex;
  assign unused_mem = hit_mem ^ bus.mem_rwrite ^ bus.mem_is_load;
`else
  // No bypass network: any in-flight writer blocks the reader.
  logic unused_ld;
  assign raw = (bus.ex_rwrite & hit_ex) | (bus.mem_rwrite & hit_mem);
  assign unused_ld = bus.ex_is_load ^ bus.mem_is_load;
`endif

  assign eval = (state_q == RUN) | (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (!eval) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_bubble = 1'b1;
      cnt_d        = cnt_q - CW'(1);
    end else begin
      state_d = RUN;
      cnt_d   = '0;
      // fdiv_start outranks a concurrent branch_taken
      priority case (1'b1)
        bus.fdiv_start: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_bubble = 1'b1;
          state_d      = FBUSY;
          cnt_d        = CNT_INIT;
        end
        bus.branch_taken: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        raw: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_d = stall_q +
    ((~pc_we & ~&stall_q) ? 16'd1 : 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.idex_we      = idex_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.fpu_busy     = (state_q == FBUSY) | bus.fdiv_start;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed + random bench for idex_hazard_ctrl against a
// cycle-level occupancy/hazard model.
module tb_idex_hazard_ctrl;

  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  idex_hazard_if bus ();

  idex_hazard_ctrl #(.FDIV_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model: occ = EX divide cycles still to come after this one
  int occ = 0;
  int sc  = 0;
  bit m_ev;
  bit e_pc, e_ifid, e_idex, e_flush, e_bub, e_exb, e_fpu;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit mm(int src, bit vld, bit sflt,
                            int dst, bit dw, bit flt);
    if (!vld || sflt != flt) return 0;
    if (!flt && src == 0) return 0;
    if (dw) return (src / 2) == (dst / 2);
    return src == dst;
  endfunction

  task automatic model_eval();
    bit hx, hm, hz;
    hx = mm(bus.id_rs, bus.id_rs_vld, bus.id_src_float,
            bus.ex_dst, bus.ex_dw, bus.ex_float) ||
         mm(bus.id_rt, bus.id_rt_vld, bus.id_src_float,
            bus.ex_dst, bus.ex_dw, bus.ex_float);
    hm = mm(bus.id_rs, bus.id_rs_vld, bus.id_src_float,
            bus.mem_dst, bus.mem_dw, bus.mem_float) ||
         mm(bus.id_rt, bus.id_rt_vld, bus.id_src_float,
            bus.mem_dst, bus.mem_dw, bus.mem_float);
`ifdef IDEX_FWD_EN
    hz = bus.ex_is_load && bus.ex_rwrite && hx;
`else
    hz = (bus.ex_rwrite && hx) || (bus.mem_rwrite && hm);
`endif
    m_ev = (occ <= 1);
    e_pc = 1; e_ifid = 1; e_idex = 1;
    e_flush = 0; e_bub = 0; e_exb = 0;
    e_fpu = (occ > 0) || bus.fdiv_start;
    if (!m_ev || bus.fdiv_start) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exb = 1;
    end else if (bus.branch_taken) begin
      e_flush = 1; e_bub = 1;
    end else if (hz) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end
  endtask

  task automatic step(input bit do_chk);
    @(negedge clk);
    model_eval();
    if (do_chk) begin
      chk("pc_we", bus.pc_we, e_pc);
      chk("ifid_we", bus.ifid_we, e_ifid);
      chk("idex_we", bus.idex_we, e_idex);
      chk("ifid_flush", bus.ifid_flush, e_flush);
      chk("idex_bubble", bus.idex_bubble, e_bub);
      chk("exmem_bubble", bus.exmem_bubble, e_exb);
      chk("fpu_busy", bus.fpu_busy, e_fpu);
      chk("stall_cycles", bus.stall_cycles, sc);
    end
    @(posedge clk);
    if (m_ev && bus.fdiv_start) occ = LAT - 1;
    else if (occ > 0) occ--;
    if (!e_pc && sc < 65535) sc++;
    #1;
  endtask

  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0;
    bus.id_rs_vld = 0; bus.id_rt_vld = 0; bus.id_src_float = 0;
    bus.ex_dst = 0; bus.mem_dst = 0;
    bus.ex_rwrite = 0; bus.mem_rwrite = 0;
    bus.ex_float = 0; bus.mem_float = 0;
    bus.ex_dw = 0; bus.mem_dw = 0;
    bus.ex_is_load = 0; bus.mem_is_load = 0;
    bus.fdiv_start = 0; bus.branch_taken = 0;
  endtask

  task automatic load_use(input int r);
    idle();
    bus.ex_dst = 5'(r); bus.ex_rwrite = 1; bus.ex_is_load = 1;
    bus.id_rs = 5'(r); bus.id_rs_vld = 1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 0;
    occ = 0; sc = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    idle();
    #12;
    chk("rst_pc_we", bus.pc_we, 1);
    chk("rst_ifid_we", bus.ifid_we, 1);
    chk("rst_idex_we", bus.idex_we, 1);
    chk("rst_flush", bus.ifid_flush, 0);
    chk("rst_bubble", bus.idex_bubble, 0);
    chk("rst_exmem", bus.exmem_bubble, 0);
    chk("rst_fpu", bus.fpu_busy, 0);
    chk("rst_stall", bus.stall_cycles, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    load_use(5);
    #1;
    chk("lu_pc_we", bus.pc_we, 0);
    chk("lu_bubble", bus.idex_bubble, 1);
    step(1);
    idle();
    #1;
    chk("lu_after_pc", bus.pc_we, 1);
    chk("lu_count", bus.stall_cycles, 1);
    step(1);

    load_use(0);
    #1;
    chk("lu_r0_pc", bus.pc_we, 1);
    step(1);

    idle();
    bus.ex_float = 1; bus.ex_dw = 1; bus.ex_dst = 6;
    bus.ex_rwrite = 1; bus.ex_is_load = 1;
    bus.id_src_float = 1; bus.id_rt = 7; bus.id_rt_vld = 1;
    #1;
    chk("dw_pc", bus.pc_we, 0);
    step(1);
    bus.id_src_float = 0;
    #1;
    chk("dw_int_pc", bus.pc_we, 1);
    step(1);

    idle();
    base = sc;
    for (int i = 0; i < 9; i++) begin
      bus.fdiv_start = (i == 0);
      #1;
      chk("div_pc", bus.pc_we, (i < 7) ? 0 : 1);
      chk("div_fpu", bus.fpu_busy, (i <= 7) ? 1 : 0);
      step(1);
    end
    chk("div_count", bus.stall_cycles, base + 7);

    load_use(9);
    bus.branch_taken = 1;
    #1;
    chk("br_flush", bus.ifid_flush, 1);
    chk("br_bubble", bus.idex_bubble, 1);
    chk("br_pc", bus.pc_we, 1);
    step(1);
    idle();
    bus.branch_taken = 1; bus.fdiv_start = 1;
    #1;
    chk("brdiv_flush", bus.ifid_flush, 0);
    chk("brdiv_pc", bus.pc_we, 0);
    chk("brdiv_fpu", bus.fpu_busy, 1);
    step(1);
    idle();
    repeat (LAT) step(1);

    idle();
    base = sc;
    bus.ex_dst = 3; bus.ex_rwrite = 1;
    bus.id_rs = 3; bus.id_rs_vld = 1;
    step(1);
    bus.ex_rwrite = 0; bus.mem_dst = 3; bus.mem_rwrite = 1;
    step(1);
    bus.mem_rwrite = 0;
    #1;
`ifdef IDEX_FWD_EN
    chk("raw_count", bus.stall_cycles, base);
`else
    chk("raw_count", bus.stall_cycles, base + 2);
`endif
    step(1);

    idle();
    bus.fdiv_start = 1;
    step(1);
    bus.fdiv_start = 0;
    repeat (3) step(1);
    #2;
    rst_n = 0;
    occ = 0; sc = 0;
    #1;
    chk("mid_rst_fpu", bus.fpu_busy, 0);
    chk("mid_rst_stall", bus.stall_cycles, 0);
    chk("mid_rst_pc", bus.pc_we, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    step(1);

    for (int i = 0; i < 400; i++) begin
      bus.id_rs = 5'($urandom_range(0, 7));
      bus.id_rt = 5'($urandom_range(0, 7));
      bus.id_rs_vld = 1'($urandom);
      bus.id_rt_vld = 1'($urandom);
      bus.id_src_float = 1'($urandom);
      bus.ex_dst = 5'($urandom_range(0, 7));
      bus.mem_dst = 5'($urandom_range(0, 7));
      bus.ex_rwrite = 1'($urandom);
      bus.mem_rwrite = 1'($urandom);
      bus.ex_float = 1'($urandom);
      bus.mem_float = 1'($urandom);
      bus.ex_dw = 1'($urandom) & bus.ex_float;
      bus.mem_dw = 1'($urandom) & bus.mem_float;
      bus.ex_is_load = 1'($urandom);
      bus.mem_is_load = 1'($urandom);
      bus.fdiv_start = ($urandom_range(0, 15) == 0);
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      step(1);
    end

    idle();
    pulse_reset();
    load_use(4);
    repeat (65534) step(0);
    chk("sat_pre", bus.stall_cycles, 16'hFFFE);
    repeat (3) step(1);
    chk("sat_ffff", bus.stall_cycles, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
